// File: rtl/mem_access_ctrl_pkg.sv
// Shared processor definitions for the data-memory access controller:
// FSM encoding, bus widths and the default memory timeout.
package mem_access_ctrl_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_t;

   localparam int DATA_W          = 16;
   localparam int CNT_W           = 8;
   localparam int DEFAULT_TIMEOUT = 16;
endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/response bus: one-cycle request strobe out, one-cycle completion strobe back.
// master = access controller, slave = data memory.
interface mem_access_ctrl_if;
   import mem_access_ctrl_pkg::*;

   logic              memEn;
   logic              memWr;
   logic [DATA_W-1:0] memAddr;
   logic [DATA_W-1:0] memWrData;
   logic              memDone;
   logic [DATA_W-1:0] memRdData;

   modport master (output memEn, memWr, memAddr, memWrData, input memDone, memRdData);
   modport slave  (input memEn, memWr, memAddr, memWrData, output memDone, memRdData);
endinterface

// File: rtl/mem_access_ctrl_wait_counter.sv
// Register cell with synchronous reset and load enable, and the 8-bit memory wait counter built from it.
// Counter: clear has priority over enable; both take effect at the next rising edge.
module dff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk) begin
      if (rst)     q <= '0;
      else if (en) q <= d;
   end
endmodule

module wait_counter
   import mem_access_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count
);
   logic [CNT_W-1:0] countNext;
   logic             load;

   assign load      = clr | en;
   assign countNext = clr ? '0 : count + 1'b1;

   dff #(.W(CNT_W)) uCount (.clk(clk), .rst(rst), .en(load), .d(countNext), .q(count));
endmodule

// File: rtl/mem_access_ctrl.sv
// EX/MEM data-memory access controller: issues one request, stalls the pipeline until completion,
// releases for one DONE cycle; misalignment or timeout lands in a sticky ERR state.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic [DATA_W-1:0] ALURes,
   input  logic [DATA_W-1:0] readData2,
   output logic [DATA_W-1:0] readDataOut,
   output logic              stall,
   output logic              err,
   mem_access_ctrl_if.master mem
);
   state_t            state;
   state_t            nextState;
   logic [CNT_W-1:0]  waitCnt;
   logic              cntClr;
   logic              cntEn;
   logic              issue;
   logic              capture;
   logic              memEnC;
   logic              memWrQ;
   logic [DATA_W-1:0] memAddrQ;
   logic [DATA_W-1:0] memWrDataQ;
   logic              req;

   assign req = memRead | memWrite;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   always_comb begin
      nextState = state;
      memEnC    = 1'b0;
      stall     = 1'b0;
      issue     = 1'b0;
      capture   = 1'b0;
      cntClr    = 1'b0;
      cntEn     = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               stall = 1'b1;
               if (ALURes[0]) begin
                  nextState = ERR;
               end else begin
                  memEnC    = 1'b1;
                  issue     = 1'b1;
                  nextState = WAIT;
               end
            end
         end
         WAIT: begin
            stall = 1'b1;
            if (mem.memDone) begin
               // Stores leave the last load result in place.
               capture   = ~memWrQ;
               cntClr    = 1'b1;
               nextState = DONE;
            end else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
               cntClr    = 1'b1;
               nextState = ERR;
            end else begin
               cntEn = 1'b1;
            end
         end
         DONE: nextState = IDLE;
         ERR:  stall = 1'b1;
      endcase
      if (rst) begin
         memEnC  = 1'b0;
         stall   = 1'b0;
         issue   = 1'b0;
         capture = 1'b0;
      end
   end

   // Write wins when both load and store are requested.
   dff #(.W(1))      uMemWr     (.clk(clk), .rst(rst), .en(issue),   .d(memWrite),      .q(memWrQ));
   dff #(.W(DATA_W)) uMemAddr   (.clk(clk), .rst(rst), .en(issue),   .d(ALURes),        .q(memAddrQ));
   dff #(.W(DATA_W)) uMemWrData (.clk(clk), .rst(rst), .en(issue),   .d(readData2),     .q(memWrDataQ));
   dff #(.W(DATA_W)) uRdData    (.clk(clk), .rst(rst), .en(capture), .d(mem.memRdData), .q(readDataOut));
   dff #(.W(1))      uErr       (.clk(clk), .rst(rst), .en(nextState == ERR), .d(1'b1), .q(err));

   wait_counter uWaitCnt (.clk(clk), .rst(rst), .clr(cntClr), .en(cntEn), .count(waitCnt));

   assign mem.memEn     = memEnC;
   assign mem.memWr     = memWrQ;
   assign mem.memAddr   = memAddrQ;
   assign mem.memWrData = memWrDataQ;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: bus requests are scoreboarded against expectations
// queued when each request is driven; latency, stall, error and reset behaviour checked per scenario.
module tb_mem_access_ctrl;
   typedef struct packed {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] data;
   } busRec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        memRead = 1'b0;
   logic        memWrite = 1'b0;
   logic [15:0] ALURes = 16'h0;
   logic [15:0] readData2 = 16'h0;
   logic [15:0] readDataOut;
   logic        stall;
   logic        err;

   int nCmp = 0;
   int nErr = 0;
   int consecEn = 0;
   busRec_t expQ[$];
   busRec_t obsQ[$];

   mem_access_ctrl_if memIf ();

   mem_access_ctrl #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite), .ALURes(ALURes),
      .readData2(readData2), .readDataOut(readDataOut), .stall(stall), .err(err), .mem(memIf)
   );

   always #5 clk = ~clk;

   // Bus monitor: the request registers are visible the cycle after the memEn strobe.
   bit capNext = 0;
   bit prevEn = 0;
   always @(negedge clk) begin
      if (capNext) obsQ.push_back('{memIf.memWr, memIf.memAddr, memIf.memWrData});
      capNext = (memIf.memEn === 1'b1);
      if (prevEn && memIf.memEn === 1'b1) consecEn++;
      prevEn = (memIf.memEn === 1'b1);
   end

   task automatic doReset();
      rst = 1'b1; memRead = 1'b0; memWrite = 1'b0;
      memIf.memDone = 1'b0; memIf.memRdData = 16'h0;
      @(posedge clk); #1;
      rst = 1'b0;
      expQ.delete(); obsQ.delete();
   endtask

   // Drives one request and a memory answering after waitCycles silent WAIT cycles.
   task automatic runReq(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                         input int waitCycles, input logic [15:0] rdData,
                         output int stallCnt, output int enCnt, output logic [15:0] rdOut, output bit released);
      memRead = rd; memWrite = wr; ALURes = addr; readData2 = wdata;
      expQ.push_back('{wr, addr, wdata});
      stallCnt = 0; enCnt = 0; released = 0; rdOut = 16'hxxxx;
      for (int c = 0; c < 64 && !released; c++) begin
         memIf.memDone   = (c == waitCycles + 1);
         memIf.memRdData = memIf.memDone ? rdData : 16'h0;
         @(negedge clk);
         if (memIf.memEn === 1'b1) enCnt++;
         if (stall === 1'b0) begin released = 1; rdOut = readDataOut; end
         else stallCnt++;
         @(posedge clk); #1;
         memRead = 1'b0; memWrite = 1'b0;
      end
      memIf.memDone = 1'b0;
   endtask

   task automatic test_reset();
      busRec_t r;
      rst = 1'b1; memRead = 1'b1; ALURes = 16'h0010;
      @(negedge clk);
      nCmp++; if (memIf.memEn !== 1'b0) begin nErr++; $display("FAIL rst_memEn: got %b want 0", memIf.memEn); end
      nCmp++; if (stall !== 1'b0) begin nErr++; $display("FAIL rst_stall: got %b want 0", stall); end
      @(posedge clk); #1;
      memRead = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      r = '{memIf.memWr, memIf.memAddr, memIf.memWrData};
      nCmp++; if (r !== 33'h0) begin nErr++; $display("FAIL rst_bus: got %h want 0", r); end
      nCmp++; if (readDataOut !== 16'h0) begin nErr++; $display("FAIL rst_rdData: got %h want 0000", readDataOut); end
      nCmp++; if ({err, stall, memIf.memEn} !== 3'b000) begin nErr++; $display("FAIL rst_flags: got %b want 000", {err, stall, memIf.memEn}); end
      @(posedge clk); #1;
      expQ.delete(); obsQ.delete();
   endtask

   task automatic test_load();
      int sc, ec; logic [15:0] rd; bit rel; busRec_t o, e;
      runReq(1'b1, 1'b0, 16'h0010, 16'h0000, 3, 16'hBEEF, sc, ec, rd, rel);
      nCmp++; if (rel !== 1'b1 || sc != 5) begin nErr++; $display("FAIL load_stall: got %0d cycles want 5", sc); end
      nCmp++; if (ec != 1) begin nErr++; $display("FAIL load_memEn: got %0d pulses want 1", ec); end
      nCmp++; if (rd !== 16'hBEEF) begin nErr++; $display("FAIL load_data: got %h want beef", rd); end
      nCmp++;
      if (obsQ.size() == 0 || expQ.size() == 0) begin nErr++; $display("FAIL load_bus: got %0d records want 1", obsQ.size()); end
      else begin o = obsQ.pop_front(); e = expQ.pop_front();
         if (o !== e) begin nErr++; $display("FAIL load_bus: got %h want %h", o, e); end end
   endtask

   task automatic test_store();
      int sc, ec; logic [15:0] rd; bit rel; busRec_t o, e;
      runReq(1'b0, 1'b1, 16'h0020, 16'h1234, 0, 16'h5555, sc, ec, rd, rel);
      nCmp++; if (rel !== 1'b1 || sc != 2) begin nErr++; $display("FAIL store_stall: got %0d cycles want 2", sc); end
      nCmp++; if (rd !== 16'hBEEF) begin nErr++; $display("FAIL store_rdKeep: got %h want beef", rd); end
      nCmp++;
      if (obsQ.size() == 0 || expQ.size() == 0) begin nErr++; $display("FAIL store_bus: got %0d records want 1", obsQ.size()); end
      else begin o = obsQ.pop_front(); e = expQ.pop_front();
         if (o !== e) begin nErr++; $display("FAIL store_bus: got %h want %h", o, e); end end
      // A stray completion while idle must not disturb the captured load data.
      memIf.memDone = 1'b1; memIf.memRdData = 16'h7777;
      @(posedge clk); #1;
      memIf.memDone = 1'b0;
      @(negedge clk);
      nCmp++; if (readDataOut !== 16'hBEEF) begin nErr++; $display("FAIL idle_done: got %h want beef", readDataOut); end
      @(posedge clk); #1;
   endtask

   task automatic test_read_write_both();
      int sc, ec; logic [15:0] rd; bit rel; busRec_t o, e;
      runReq(1'b1, 1'b1, 16'h0022, 16'hCAFE, 1, 16'h9999, sc, ec, rd, rel);
      nCmp++; if (rel !== 1'b1 || sc != 3) begin nErr++; $display("FAIL both_stall: got %0d cycles want 3", sc); end
      nCmp++; if (rd !== 16'hBEEF) begin nErr++; $display("FAIL both_rdKeep: got %h want beef", rd); end
      nCmp++;
      if (obsQ.size() == 0 || expQ.size() == 0) begin nErr++; $display("FAIL both_bus: got %0d records want 1", obsQ.size()); end
      else begin o = obsQ.pop_front(); e = expQ.pop_front();
         if (o !== e) begin nErr++; $display("FAIL both_bus: got %h want %h", o, e); end end
   endtask

   task automatic test_misaligned();
      int ec = 0;
      doReset();
      memRead = 1'b1; ALURes = 16'h0011;
      @(negedge clk);
      nCmp++; if ({memIf.memEn, stall, err} !== 3'b010) begin nErr++; $display("FAIL mis_issue: got %b want 010", {memIf.memEn, stall, err}); end
      @(posedge clk); #1;
      memRead = 1'b0; memIf.memDone = 1'b1; memIf.memRdData = 16'h4444;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (memIf.memEn === 1'b1) ec++;
         if (c == 0) begin
            nCmp++; if ({err, stall} !== 2'b11) begin nErr++; $display("FAIL mis_err: got %b want 11", {err, stall}); end
         end
         @(posedge clk); #1;
         memIf.memDone = 1'b0;
      end
      nCmp++; if (ec != 0) begin nErr++; $display("FAIL mis_memEn: got %0d pulses want 0", ec); end
      nCmp++; if (readDataOut !== 16'h0) begin nErr++; $display("FAIL err_done: got %h want 0000", readDataOut); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      nCmp++; if ({err, stall} !== 2'b00) begin nErr++; $display("FAIL mis_rst: got %b want 00", {err, stall}); end
      @(posedge clk); #1;
   endtask

   task automatic test_timeout();
      int waits = 0; bit hit = 0; busRec_t o, e;
      doReset();
      memRead = 1'b1; ALURes = 16'h0040; readData2 = 16'h0;
      expQ.push_back('{1'b0, 16'h0040, 16'h0000});
      @(posedge clk); #1;
      memRead = 1'b0;
      for (int c = 0; c < 100 && !hit; c++) begin
         @(negedge clk);
         if (err === 1'b1) hit = 1;
         else waits++;
         @(posedge clk); #1;
      end
      nCmp++; if (!hit || waits != 16) begin nErr++; $display("FAIL timeout_wait: got %0d WAIT cycles want 16", waits); end
      @(negedge clk);
      nCmp++; if ({err, stall, memIf.memEn} !== 3'b110) begin nErr++; $display("FAIL timeout_err: got %b want 110", {err, stall, memIf.memEn}); end
      nCmp++;
      if (obsQ.size() == 0 || expQ.size() == 0) begin nErr++; $display("FAIL timeout_bus: got %0d records want 1", obsQ.size()); end
      else begin o = obsQ.pop_front(); e = expQ.pop_front();
         if (o !== e) begin nErr++; $display("FAIL timeout_bus: got %h want %h", o, e); end end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_wait();
      int sc, ec; logic [15:0] rd; bit rel;
      doReset();
      runReq(1'b1, 1'b0, 16'h0050, 16'h0000, 0, 16'hA5A5, sc, ec, rd, rel);
      nCmp++; if (rd !== 16'hA5A5) begin nErr++; $display("FAIL rmw_load: got %h want a5a5", rd); end
      memRead = 1'b1; ALURes = 16'h0052;
      @(posedge clk); #1;
      memRead = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; memIf.memDone = 1'b1; memIf.memRdData = 16'hFFFF;
      @(negedge clk);
      nCmp++; if ({stall, memIf.memEn} !== 2'b00) begin nErr++; $display("FAIL rmw_idle: got %b want 00", {stall, memIf.memEn}); end
      @(posedge clk); #1;
      memIf.memDone = 1'b0;
      @(negedge clk);
      nCmp++; if (readDataOut !== 16'h0) begin nErr++; $display("FAIL rmw_data: got %h want 0000", readDataOut); end
      nCmp++; if ({err, stall, memIf.memEn} !== 3'b000) begin nErr++; $display("FAIL rmw_flags: got %b want 000", {err, stall, memIf.memEn}); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int pulses = 0, gap = 99, minGap = 99, pend = 0, bad = 0;
      logic [15:0] lastRd = 16'h0;
      busRec_t o, e;
      doReset();
      memRead = 1'b1; ALURes = 16'h0030; readData2 = 16'h0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (memIf.memEn === 1'b1) begin
            pulses++;
            if (gap < minGap) minGap = gap;
            gap = 0; pend = 2;
            expQ.push_back('{1'b0, 16'h0030, 16'h0000});
         end else gap++;
         @(posedge clk); #1;
         memIf.memDone = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin memIf.memDone = 1'b1; lastRd = 16'h1000 + 16'(c); memIf.memRdData = lastRd; end
         end
      end
      memIf.memDone = 1'b0;
      nCmp++; if (pulses != 10) begin nErr++; $display("FAIL b2b_pulses: got %0d want 10", pulses); end
      nCmp++; if (minGap != 3 || consecEn != 0) begin nErr++; $display("FAIL b2b_gap: got gap %0d consec %0d want gap 3 consec 0", minGap, consecEn); end
      nCmp++; if (readDataOut !== lastRd) begin nErr++; $display("FAIL b2b_data: got %h want %h", readDataOut, lastRd); end
      while (expQ.size() > 0 && obsQ.size() > 0) begin
         o = obsQ.pop_front(); e = expQ.pop_front();
         if (o !== e) bad++;
      end
      nCmp++; if (bad != 0 || expQ.size() != 0) begin nErr++; $display("FAIL b2b_bus: got %0d bad %0d unmatched want 0 0", bad, expQ.size()); end
      memRead = 1'b0;
      doReset();
   endtask

   initial begin
      memIf.memDone = 1'b0; memIf.memRdData = 16'h0;
      test_reset();
      test_load();
      test_store();
      test_read_write_both();
      test_misaligned();
      test_timeout();
      test_reset_mid_wait();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end
endmodule
